// File: rtl/mcu_block_scheduler_if.sv
// axi4_stream_if: AXI4-Stream bundle with master/slave views
interface axi4_stream_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0]         tdata;
  logic [(DW+7)/8-1:0]   tkeep;
  logic [(DW+7)/8-1:0]   tstrb;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;
  modport master (output tdata, tkeep, tstrb, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tkeep, tstrb, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/mcu_block_scheduler.sv
// mcu_block_scheduler: grants whole Y/Cb/Cr 8x8 blocks to the shared block path in MCU order
module mcu_block_scheduler #(
  parameter int PX_WIDTH   = 8,
  parameter int MAT_SIZE   = 8,
  parameter bit CHROMA_420 = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  y_i,
  axi4_stream_if.slave  cb_i,
  axi4_stream_if.slave  cr_i,
  axi4_stream_if.master video_o,
  output logic [1:0]    comp_o,
  output logic          mcu_start_o,
  output logic          frame_done_o
);
  localparam int BW = $clog2(MAT_SIZE * MAT_SIZE);
  localparam logic [BW-1:0] LAST = BW'(MAT_SIZE * MAT_SIZE - 1);

  typedef enum logic [1:0] {SYNC, SEL_Y, SEL_CB, SEL_CR} state_t;

  state_t state, state_nx;
  logic [BW-1:0] beat_cnt;
  logic [1:0] y_cnt;
  logic [1:0] comp_nx;
  logic [PX_WIDTH-1:0] in_data, vo_data;
  logic vo_valid, vo_user, vo_last;
  logic dp_rdy, acc, blk_end, in_user, in_last, mcu_nx;

  assign dp_rdy  = !vo_valid || video_o.tready;
  assign blk_end = beat_cnt == LAST;
  assign mcu_nx  = state == SYNC || (state == SEL_Y && beat_cnt == '0 && y_cnt == 2'd0);

  assign video_o.tvalid = vo_valid;
  assign video_o.tdata  = vo_data;
  assign video_o.tuser  = vo_user;
  assign video_o.tlast  = vo_last;
  assign video_o.tkeep  = '1;
  assign video_o.tstrb  = '1;

  // In SYNC non-frame-start beats are always drained; the frame-start beat waits for a free output slot
  always_comb begin
    y_i.tready  = 1'b0;
    cb_i.tready = 1'b0;
    cr_i.tready = 1'b0;
    acc         = 1'b0;
    in_data     = y_i.tdata;
    in_user     = 1'b0;
    in_last     = 1'b0;
    comp_nx     = 2'd0;
    state_nx    = state;
    case (state)
      SYNC: begin
        y_i.tready = !y_i.tuser || dp_rdy;
        acc        = y_i.tvalid && y_i.tuser && dp_rdy;
        in_user    = 1'b1;
        state_nx   = acc ? SEL_Y : SYNC;
      end
      SEL_Y: begin
        y_i.tready = dp_rdy;
        acc        = y_i.tvalid && dp_rdy;
        in_user    = y_i.tuser;
        if (acc && blk_end) state_nx = (CHROMA_420 && y_cnt != 2'd3) ? SEL_Y : SEL_CB;
      end
      SEL_CB: begin
        cb_i.tready = dp_rdy;
        acc         = cb_i.tvalid && dp_rdy;
        in_data     = cb_i.tdata;
        comp_nx     = 2'd1;
        if (acc && blk_end) state_nx = SEL_CR;
      end
      default: begin
        cr_i.tready = dp_rdy;
        acc         = cr_i.tvalid && dp_rdy;
        in_data     = cr_i.tdata;
        in_last     = cr_i.tlast && blk_end;
        comp_nx     = 2'd2;
        if (acc && blk_end) state_nx = cr_i.tlast ? SYNC : SEL_Y;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= SYNC;
    else       state <= state_nx;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt     <= '0;
      y_cnt        <= 2'd0;
      vo_valid     <= 1'b0;
      vo_data      <= '0;
      vo_user      <= 1'b0;
      vo_last      <= 1'b0;
      comp_o       <= 2'd0;
      mcu_start_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= vo_valid && video_o.tready && vo_last;
      if (acc) beat_cnt <= blk_end ? '0 : beat_cnt + BW'(1);
      if (acc && blk_end && state == SEL_Y) y_cnt <= (CHROMA_420 && y_cnt != 2'd3) ? y_cnt + 2'd1 : 2'd0;
      if (dp_rdy) vo_valid <= acc;
      if (acc) begin
        vo_data     <= in_data;
        vo_user     <= in_user;
        vo_last     <= in_last;
        comp_o      <= comp_nx;
        mcu_start_o <= mcu_nx;
      end
    end
  end
endmodule

// File: tb/tb_mcu_block_scheduler.sv
// tb_mcu_block_scheduler: scoreboard bench for 4:4:4 and 4:2:0 block scheduling
module tb_mcu_block_scheduler;
  typedef struct packed {logic [7:0] d; logic u; logic l;} beat_t;
  typedef struct packed {logic [7:0] d; logic u; logic l; logic [1:0] c; logic m;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic dsel = 1'b0;
  logic y_v = 1'b0, y_u = 1'b0, cb_v = 1'b0, cr_v = 1'b0, cr_l = 1'b0, vo_rdy = 1'b1;
  logic [7:0] y_d = '0, cb_d = '0, cr_d = '0;
  logic [1:0] yr, cbr, crr, vv, vu, vl, ms, fd;
  logic [7:0] vd [2];
  logic [1:0] cp [2];

  for (genvar g = 0; g < 2; g++) begin : gd
    axi4_stream_if #(.DW(8)) y ();
    axi4_stream_if #(.DW(8)) cb ();
    axi4_stream_if #(.DW(8)) cr ();
    axi4_stream_if #(.DW(8)) v ();
    assign y.tvalid  = y_v && (dsel == g);
    assign y.tdata   = y_d;
    assign y.tuser   = y_u;
    assign y.tlast   = 1'b0;
    assign y.tkeep   = '1;
    assign y.tstrb   = '1;
    assign cb.tvalid = cb_v && (dsel == g);
    assign cb.tdata  = cb_d;
    assign cb.tuser  = 1'b0;
    assign cb.tlast  = 1'b0;
    assign cb.tkeep  = '1;
    assign cb.tstrb  = '1;
    assign cr.tvalid = cr_v && (dsel == g);
    assign cr.tdata  = cr_d;
    assign cr.tuser  = 1'b0;
    assign cr.tlast  = cr_l;
    assign cr.tkeep  = '1;
    assign cr.tstrb  = '1;
    assign v.tready  = vo_rdy;
    assign yr[g]  = y.tready;
    assign cbr[g] = cb.tready;
    assign crr[g] = cr.tready;
    assign vv[g]  = v.tvalid;
    assign vu[g]  = v.tuser;
    assign vl[g]  = v.tlast;
    assign vd[g]  = v.tdata;
    mcu_block_scheduler #(.PX_WIDTH(8), .MAT_SIZE(8), .CHROMA_420(g == 1)) u (
      .clk_i(clk), .rst_i(rst), .y_i(y), .cb_i(cb), .cr_i(cr), .video_o(v),
      .comp_o(cp[g]), .mcu_start_o(ms[g]), .frame_done_o(fd[g]));
  end

  wire y_rdy = yr[dsel], cb_rdy = cbr[dsel], cr_rdy = crr[dsel];
  wire o_v = vv[dsel], o_u = vu[dsel], o_l = vl[dsel], o_m = ms[dsel], o_fd = fd[dsel];
  wire [7:0] o_d = vd[dsel];
  wire [1:0] o_c = cp[dsel];

  beat_t yq[$], cbq[$], crq[$];
  exp_t eq[$];
  int checks = 0, errors = 0, out_cnt = 0, fd_cnt = 0, cyc = 0, tp_n = 0, tp_first = 0, tp_last = 0;
  logic y_f = 1'b0, cb_f = 1'b0, cr_f = 1'b0, rnd = 1'b0, sync_chk = 1'b0, st_prev = 1'b0;
  logic [12:0] st_val = '0;
  logic [7:0] yc = 8'h00, cbc = 8'h80, crc = 8'hc0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // handshakes and outputs are judged mid-cycle, where every signal is settled
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    y_f  = !rst && y_v && y_rdy;
    cb_f = !rst && cb_v && cb_rdy;
    cr_f = !rst && cr_v && cr_rdy;
    if (!rst && o_v && vo_rdy) begin
      if (eq.size() == 0) check("extra_beat", 32'(o_d), 32'hffff_ffff);
      else begin
        e = eq.pop_front();
        check("beat", 32'({o_d, o_u, o_l, o_c, o_m}), 32'(e));
        out_cnt++;
        if (tp_n == 0) tp_first = cyc;
        tp_n++;
        tp_last = cyc;
      end
    end
    if (!rst && st_prev && o_v) check("stall_hold", 32'({o_d, o_u, o_l, o_c, o_m}), 32'(st_val));
    st_prev = !rst && o_v && !vo_rdy;
    st_val  = {o_d, o_u, o_l, o_c, o_m};
    if (o_fd) fd_cnt++;
    if (sync_chk) check("sync_chroma_rdy", 32'({cb_rdy, cr_rdy}), 32'd0);
  end

  always @(posedge clk) begin
    #1;
    if (y_f)  void'(yq.pop_front());
    if (cb_f) void'(cbq.pop_front());
    if (cr_f) void'(crq.pop_front());
    y_v  = yq.size() > 0;
    cb_v = cbq.size() > 0;
    cr_v = crq.size() > 0;
    if (y_v)  {y_d, y_u} = {yq[0].d, yq[0].u};
    if (cb_v) cb_d = cbq[0].d;
    if (cr_v) {cr_d, cr_l} = {crq[0].d, crq[0].l};
    vo_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic gen(input int mcus, input bit c420, input int tl_at);
    int ny = c420 ? 4 : 1;
    logic [7:0] d;
    logic [1:0] c;
    logic u, l;
    for (int m = 0; m < mcus; m++)
      for (int b = 0; b < ny + 2; b++)
        for (int i = 0; i < 64; i++) begin
          c = b < ny ? 2'd0 : (b == ny ? 2'd1 : 2'd2);
          u = m == 0 && b == 0 && i == 0;
          l = c == 2'd2 && m == mcus - 1 && i == tl_at;
          if (c == 2'd0) begin d = yc; yc++; yq.push_back({d, u, 1'b0}); end
          else if (c == 2'd1) begin d = cbc; cbc++; cbq.push_back({d, 1'b0, 1'b0}); end
          else begin d = crc; crc++; crq.push_back({d, 1'b0, l}); end
          eq.push_back({d, u, l && i == 63, c, b == 0 && i == 0});
        end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 5000 && eq.size() > 0; i++) @(negedge clk);
    check({tag, "_drain"}, 32'(eq.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    yq.delete();
    cbq.delete();
    crq.delete();
    eq.delete();
    #1;
    check("rst_out", 32'({o_v, o_d, o_u, o_l, o_c, o_m, o_fd}), 32'd0);
    check("rst_rdy", 32'({y_rdy, cb_rdy, cr_rdy}), 32'b100);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int fd0, base;
    do_reset();
    // two 4:4:4 MCUs at full rate
    tp_n = 0; fd0 = fd_cnt;
    gen(2, 1'b0, 63);
    drain("444");
    check("444_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("444_tput", 32'(tp_last - tp_first), 32'd383);
    // same frame with a randomly stalling sink
    rnd = 1'b1; fd0 = fd_cnt;
    gen(2, 1'b0, 63);
    drain("rand");
    rnd = 1'b0;
    check("rand_frame_done", 32'(fd_cnt - fd0), 32'd1);
    // luma before frame start is dropped and chroma stays blocked
    for (int i = 0; i < 10; i++) yq.push_back({8'he0 + 8'(i), 1'b0, 1'b0});
    fd0 = fd_cnt;
    gen(1, 1'b0, 63);
    sync_chk = 1'b1;
    repeat (10) @(negedge clk);
    sync_chk = 1'b0;
    drain("sync");
    check("sync_frame_done", 32'(fd_cnt - fd0), 32'd1);
    // reset in the middle of a Cb block, then a clean frame
    base = out_cnt;
    gen(1, 1'b0, 63);
    for (int i = 0; i < 2000 && out_cnt < base + 101; i++) @(negedge clk);
    check("mid_reached", 32'(out_cnt - base), 32'd101);
    do_reset();
    fd0 = fd_cnt;
    gen(1, 1'b0, 63);
    drain("post_rst");
    check("post_rst_frame_done", 32'(fd_cnt - fd0), 32'd1);
    // early Cr tlast is ignored and the schedule rolls into the next MCU
    fd0 = fd_cnt;
    gen(1, 1'b0, 10);
    drain("early_tlast");
    check("early_tlast_no_done", 32'(fd_cnt - fd0), 32'd0);
    gen(1, 1'b0, 63);
    drain("after_early");
    check("after_early_done", 32'(fd_cnt - fd0), 32'd1);
    // 4:2:0 instance
    dsel = 1'b1;
    do_reset();
    tp_n = 0; fd0 = fd_cnt;
    gen(1, 1'b1, 63);
    drain("420");
    check("420_frame_done", 32'(fd_cnt - fd0), 32'd1);
    check("420_tput", 32'(tp_last - tp_first), 32'd383);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
